button_register: RTL and testbench

CPU-readable input register for the board's push buttons, the input-side counterpart of the write-only LED register on the same decoded I/O bus. Four active-low button pins are synchronised and debounced, and each press is latched as a pending event. The CPU reads the debounced levels and pending flags, clears pending flags write-one-to-clear, and sets a per-button interrupt mask. The block drives a level interrupt request towards the interrupt controller.

---
 rtl/button_register_pkg.sv | 14 +
 rtl/button_register_if.sv | 27 ++
 rtl/button_register_debouncer.sv | 54 +++++
 rtl/button_register.sv | 81 ++++++++
 tb/tb_button_register.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/button_register_pkg.sv
// Shared constants for the push-button input register: the read-word
// field positions and the number of buttons on the board.
package button_register_pkg;

    localparam int NUM_BUTTONS = 4;

    localparam int PENDING_HI = 31;
    localparam int PENDING_LO = 28;
    localparam int PRESSED_HI = 27;
    localparam int PRESSED_LO = 24;
    localparam int MASK_HI    = 23;
    localparam int MASK_LO    = 20;

endpackage

// File: rtl/button_register_if.sv
// CPU-side bus of the button register: decoded select, write strobe,
// write data, continuously driven read data and the interrupt line.
interface button_register_if;

    logic        write;
    logic        cs;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        irq;

    modport master (
        output write,
        output cs,
        output data_in,
        input  data_out,
        input  irq
    );

    modport slave (
        input  write,
        input  cs,
        input  data_in,
        output data_out,
        output irq
    );

endinterface

// File: rtl/button_register_debouncer.sv
// One button: two-flop synchroniser, inversion to 1 = pressed, and a
// counter that only lets the debounced level follow a sample that has
// been stably different for DEBOUNCE_CYCLES clocks.
module button_register_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic button_n,
    output logic pressed,
    output logic rise
);

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                   sync_meta;
    logic                   sync_stable;
    logic                   sync_pressed;
    logic [COUNT_WIDTH-1:0] cnt;

    // Synchronise the raw pin and register its inverted (1 = pressed) form.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta    <= 1'b1;
            sync_stable  <= 1'b1;
            sync_pressed <= 1'b0;
        end else begin
            sync_meta    <= button_n;
            sync_stable  <= sync_meta;
            sync_pressed <= ~sync_stable;
        end
    end

    // Count consecutive disagreeing samples; any agreement restarts the count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            pressed <= 1'b0;
        end else if (sync_pressed == pressed) begin
            cnt <= '0;
        end else if (cnt == LAST_COUNT) begin
            pressed <= sync_pressed;
            cnt     <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // High in the cycle before the edge on which pressed goes 0 to 1, so the
    // parent can latch the event on that same edge.
    assign rise = sync_pressed && !pressed && (cnt == LAST_COUNT);

endmodule

// File: rtl/button_register.sv
// CPU-readable push-button register: debounced levels, sticky press
// events cleared write-one-to-clear, a per-button interrupt mask and a
// registered level interrupt request.
module button_register
    import button_register_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons_n,
    button_register_if.slave       bus
);

    logic [NUM_BUTTONS-1:0] pressed;
    logic [NUM_BUTTONS-1:0] rise;
    logic [NUM_BUTTONS-1:0] pending;
    logic [NUM_BUTTONS-1:0] mask;
    logic [NUM_BUTTONS-1:0] clear;
    logic                   bus_write;
    logic                   irq_q;
    logic                   unused_data_bits;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_button
        button_register_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .COUNT_WIDTH     (COUNT_WIDTH)
        ) u_debouncer (
            .clock    (clock),
            .reset    (reset),
            .button_n (buttons_n[i]),
            .pressed  (pressed[i]),
            .rise     (rise[i])
        );
    end

    assign bus_write = bus.cs && bus.write;
    assign clear     = bus_write ? bus.data_in[PENDING_HI:PENDING_LO] : '0;

    // The pressed field of a write and the unused low bits carry no meaning.
    assign unused_data_bits = ^{bus.data_in[PRESSED_HI:PRESSED_LO], bus.data_in[MASK_LO-1:0]};

    // Pending events: a new press outranks a simultaneous clear of the same bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clear) | rise;
        end
    end

    // Interrupt mask, loaded whole by any write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mask <= '0;
        end else if (bus_write) begin
            mask <= bus.data_in[MASK_HI:MASK_LO];
        end
    end

    // Level interrupt, registered from the current pending and mask.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(pending & mask);
        end
    end

    // Read word assembled straight from the registers.
    always_comb begin
        bus.data_out                        = '0;
        bus.data_out[PENDING_HI:PENDING_LO] = pending;
        bus.data_out[PRESSED_HI:PRESSED_LO] = pressed;
        bus.data_out[MASK_HI:MASK_LO]       = mask;
    end

    assign bus.irq = irq_q;

endmodule

// File: tb/tb_button_register.sv
// Directed and randomised bench for button_register with a short debounce
// window, checked against a sample-history reference model.
module tb_button_register;

    import button_register_pkg::*;

    localparam int D    = 4;
    localparam int HIST = D + 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] buttons_n = 4'hF;

    button_register_if bus ();

    button_register #(
        .DEBOUNCE_CYCLES (D),
        .COUNT_WIDTH     (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .buttons_n (buttons_n),
        .bus       (bus.slave)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    logic [3:0] m_pressed;
    logic [3:0] m_pending;
    logic [3:0] m_mask;
    logic       m_irq;
    logic [3:0] hist[$];

    int compared   = 0;
    int mismatched = 0;

    // Everything back to its reset value; the pipeline history reads released.
    task automatic model_reset();
        m_pressed = '0;
        m_pending = '0;
        m_mask    = '0;
        m_irq     = 1'b0;
        hist.delete();
        for (int i = 0; i < HIST; i++) hist.push_back(4'b0000);
    endtask

    function automatic logic [31:0] model_read();
        return {m_pending, m_pressed, m_mask, 20'h00000};
    endfunction

    task automatic apply_stimulus(input logic [3:0] pins, input logic wr, input logic [31:0] data);
        buttons_n   = pins;
        bus.cs      = wr;
        bus.write   = wr;
        bus.data_in = data;
    endtask

    // One clock edge: the model applies the level-follows-stable-window rule
    // to samples taken three edges earlier, then sampling moves off the edge.
    task automatic tick();
        logic [3:0]  sample;
        logic [3:0]  new_pressed;
        logic [3:0]  rise;
        logic        wr;
        logic [31:0] d;
        bit          stable;
        sample = ~buttons_n;
        wr     = bus.cs && bus.write;
        d      = bus.data_in;
        @(posedge clock);
        if (!reset) begin
            model_reset();
        end else begin
            new_pressed = m_pressed;
            for (int b = 0; b < 4; b++) begin
                stable = 1'b1;
                for (int j = 1; j <= D; j++)
                    if (hist[j][b] == m_pressed[b]) stable = 1'b0;
                if (stable) new_pressed[b] = ~m_pressed[b];
            end
            rise      = new_pressed & ~m_pressed;
            m_irq     = |(m_pending & m_mask);
            m_pending = (m_pending & ~(wr ? d[31:28] : 4'b0000)) | rise;
            if (wr) m_mask = d[23:20];
            m_pressed = new_pressed;
            hist.push_back(sample);
            void'(hist.pop_front());
        end
        #1;
    endtask

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        check_value({tag, "_data"}, bus.data_out, model_read());
        check_value({tag, "_irq"}, 32'(bus.irq), 32'(m_irq));
    endtask

    task automatic tick_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_output(tag);
        end
    endtask

    // Safety net in case the run ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not reach the summary");
        $fatal(1, "[TB] timeout");
    end

    // Directed scenarios followed by a randomised run.
    initial begin
        logic [3:0] bounce_pins[7];
        logic [3:0] pins;
        apply_stimulus(4'hF, 1'b0, 32'h0);
        model_reset();

        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_output("reset_async");
        check_value("reset_zero", bus.data_out, 32'h00000000);
        tick_check("reset_hold", 2);
        reset = 1'b1;

        $display("[TB] clean press on button 0");
        apply_stimulus(4'b1110, 1'b0, 32'h0);
        tick_check("clean_press", 7);
        check_value("clean_press_word", bus.data_out, 32'h11000000);
        check_value("clean_press_irq", 32'(bus.irq), 32'h0);

        apply_stimulus(4'b1110, 1'b1, 32'h00100000);
        tick();
        apply_stimulus(4'b1110, 1'b0, 32'h0);
        check_output("mask_write");
        check_value("mask_irq_not_yet", 32'(bus.irq), 32'h0);
        tick();
        check_output("mask_irq_follow");
        check_value("mask_irq", 32'(bus.irq), 32'h1);

        $display("[TB] bounce rejection on button 1");
        bounce_pins = '{4'b1100, 4'b1100, 4'b1100, 4'b1110, 4'b1100, 4'b1100, 4'b1100};
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(bounce_pins[i], 1'b0, 32'h0);
            tick();
            check_output("bounce");
            check_value("bounce_bit1", 32'({bus.data_out[29], bus.data_out[25]}), 32'h0);
        end
        tick_check("bounce_hold", 3);
        check_value("bounce_still_low", 32'(bus.data_out[25]), 32'h0);
        tick_check("bounce_settle", 1);
        check_value("bounce_pressed", 32'(bus.data_out[25]), 32'h1);

        $display("[TB] write-one-to-clear");
        apply_stimulus(4'b1100, 1'b1, 32'h10100000);
        tick();
        apply_stimulus(4'b1100, 1'b0, 32'h0);
        check_output("w1c");
        check_value("w1c_pending", 32'(bus.data_out[31:28]), 32'h2);

        apply_stimulus(4'b1101, 1'b0, 32'h0);
        tick_check("w1c_release0", 8);
        apply_stimulus(4'b1100, 1'b0, 32'h0);
        tick_check("w1c_repress0", 6);
        apply_stimulus(4'b1100, 1'b1, 32'h10100000);
        tick();
        apply_stimulus(4'b1100, 1'b0, 32'h0);
        check_output("set_wins");
        check_value("set_wins_pending0", 32'(bus.data_out[28]), 32'h1);
        apply_stimulus(4'b1100, 1'b1, 32'h10100000);
        tick();
        apply_stimulus(4'b1100, 1'b0, 32'h0);
        check_output("w1c_plain");
        check_value("w1c_plain_pending0", 32'(bus.data_out[28]), 32'h0);

        $display("[TB] release and re-press of button 2");
        apply_stimulus(4'b1000, 1'b0, 32'h0);
        tick_check("press2", 8);
        apply_stimulus(4'b1100, 1'b0, 32'h0);
        tick_check("release2", 8);
        check_value("release2_level", 32'(bus.data_out[26]), 32'h0);
        check_value("release2_pending", 32'(bus.data_out[30]), 32'h1);
        apply_stimulus(4'b1000, 1'b0, 32'h0);
        tick_check("repress2", 8);
        check_value("repress2_level", 32'(bus.data_out[26]), 32'h1);

        $display("[TB] reset in the middle of a debounce");
        apply_stimulus(4'b0000, 1'b0, 32'h0);
        tick_check("mid_debounce", 2);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_value("mid_reset_zero", bus.data_out, 32'h00000000);
        check_value("mid_reset_irq", 32'(bus.irq), 32'h0);
        tick_check("mid_reset_hold", 2);
        reset = 1'b1;
        tick_check("after_release", 6);
        check_value("after_release_early", bus.data_out, 32'h00000000);
        tick_check("after_release_done", 1);
        check_value("after_release_word", bus.data_out, 32'hFF000000);

        $display("[TB] randomised run");
        pins = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(5) == 0) pins[$urandom_range(3)] ^= 1'b1;
            if ($urandom_range(7) == 0)
                apply_stimulus(pins, 1'b1, $urandom);
            else
                apply_stimulus(pins, 1'b0, $urandom);
            tick();
            check_output("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
